// File: rtl/buyruk_sirala_if.sv
// Program-write and result-output handshake channels of buyruk_sirala.
// The issuer side uses the slave modport; the producer/consumer side uses master.
interface buyruk_sirala_if #(
   parameter int W  = 9,
   parameter int RW = 4
);
   logic          yaz_gecerli;
   logic [W-1:0]  yaz_veri;
   logic          yaz_hazir;
   logic          cikis_gecerli;
   logic [RW-1:0] cikis_veri;
   logic          cikis_hazir;

   modport slave (
      input  yaz_gecerli,
      input  yaz_veri,
      output yaz_hazir,
      output cikis_gecerli,
      output cikis_veri,
      input  cikis_hazir
   );

   modport master (
      output yaz_gecerli,
      output yaz_veri,
      input  yaz_hazir,
      input  cikis_gecerli,
      input  cikis_veri,
      output cikis_hazir
   );
endinterface

// File: rtl/buyruk_sirala.sv
// Sequential issuer for the combinational bibp ALU: buffers program words,
// issues them one at a time and returns each captured result in order.
module buyruk_sirala #(
   parameter int N        = 3,
   parameter int DERINLIK = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   buyruk_sirala_if.slave       bus,
   input  logic                 basla,
   output logic [2*N+2:0]       buyruk,
   input  logic [N:0]           sonuc_gir,
   output logic                 mesgul,
   output logic                 bitti
);
   localparam int W  = 2*N + 3;
   localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
   localparam logic [AW:0] DOLU = (AW+1)'(DERINLIK);

   typedef enum logic [1:0] {BOS, GONDER, YAKALA, CIKIS} durum_t;

   durum_t        durum_reg;
   logic [W-1:0]  mem [DERINLIK];
   logic [AW-1:0] oku_ptr_reg;
   logic [AW-1:0] yaz_ptr_reg;
   logic [AW:0]   sayac_reg;
   logic [W-1:0]  buyruk_reg;
   logic [N:0]    cikis_veri_reg;
   logic          cikis_gecerli_reg;
   logic          mesgul_reg;
   logic          bitti_reg;

   logic yaz_hazir;
   logic yaz_en;

   assign yaz_hazir = (durum_reg == BOS) && (sayac_reg < DOLU);
   assign yaz_en    = bus.yaz_gecerli && yaz_hazir;

   assign bus.yaz_hazir     = yaz_hazir;
   assign bus.cikis_gecerli = cikis_gecerli_reg;
   assign bus.cikis_veri    = cikis_veri_reg;
   assign buyruk            = buyruk_reg;
   assign mesgul            = mesgul_reg;
   assign bitti             = bitti_reg;

   // Program storage: write-only port here, read is registered into buyruk.
   always_ff @(posedge clk) begin
      if (yaz_en) begin
         mem[yaz_ptr_reg] <= bus.yaz_veri;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         durum_reg         <= BOS;
         oku_ptr_reg       <= '0;
         yaz_ptr_reg       <= '0;
         sayac_reg         <= '0;
         buyruk_reg        <= '0;
         cikis_veri_reg    <= '0;
         cikis_gecerli_reg <= 1'b0;
         mesgul_reg        <= 1'b0;
         bitti_reg         <= 1'b0;
      end else begin
         bitti_reg <= 1'b0;
         case (durum_reg)
            BOS: begin
               if (yaz_en) begin
                  yaz_ptr_reg <= yaz_ptr_reg + AW'(1);
                  sayac_reg   <= sayac_reg + (AW+1)'(1);
               end
               // A word written in the same cycle as basla joins the run.
               if (basla && ((sayac_reg != '0) || yaz_en)) begin
                  durum_reg  <= GONDER;
                  mesgul_reg <= 1'b1;
               end
            end
            GONDER: begin
               buyruk_reg <= mem[oku_ptr_reg];
               durum_reg  <= YAKALA;
            end
            YAKALA: begin
               cikis_veri_reg    <= sonuc_gir;
               cikis_gecerli_reg <= 1'b1;
               durum_reg         <= CIKIS;
            end
            CIKIS: begin
               if (bus.cikis_hazir) begin
                  cikis_gecerli_reg <= 1'b0;
                  oku_ptr_reg       <= oku_ptr_reg + AW'(1);
                  sayac_reg         <= sayac_reg - (AW+1)'(1);
                  if (sayac_reg == (AW+1)'(1)) begin
                     bitti_reg  <= 1'b1;
                     mesgul_reg <= 1'b0;
                     durum_reg  <= BOS;
                  end else begin
                     durum_reg <= GONDER;
                  end
               end
            end
            default: durum_reg <= BOS;
         endcase
      end
   end
endmodule

// File: tb/tb_buyruk_sirala.sv
// Directed bench for buyruk_sirala with a small bibp model (add/sub/and)
// driving sonuc_gir from buyruk.
module tb_buyruk_sirala;
   logic       clk = 1'b0;
   logic       rst;
   logic       basla;
   logic [8:0] buyruk;
   logic [3:0] sonuc_gir;
   logic       mesgul;
   logic       bitti;

   int n_assert = 0;
   int n_fail   = 0;

   buyruk_sirala_if #(.W(9), .RW(4)) bus();

   buyruk_sirala #(.N(3), .DERINLIK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .basla     (basla),
      .buyruk    (buyruk),
      .sonuc_gir (sonuc_gir),
      .mesgul    (mesgul),
      .bitti     (bitti)
   );

   always #5 clk = ~clk;

   // Reference ALU: opcode [8:6], a [5:3], b [2:0], 4-bit result with wrap.
   always_comb begin
      sonuc_gir = 4'd0;
      case (buyruk[8:6])
         3'd0: sonuc_gir = {1'b0, buyruk[5:3]} + {1'b0, buyruk[2:0]};
         3'd1: sonuc_gir = {1'b0, buyruk[5:3]} - {1'b0, buyruk[2:0]};
         3'd2: sonuc_gir = {1'b0, buyruk[5:3] & buyruk[2:0]};
         default: sonuc_gir = 4'd0;
      endcase
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [8:0] w);
      bus.yaz_gecerli = 1'b1;
      bus.yaz_veri    = w;
      step();
      bus.yaz_gecerli = 1'b0;
   endtask

   task automatic start();
      basla = 1'b1;
      step();
      basla = 1'b0;
   endtask

   // Entered one cycle after start or after a handshake, with cikis_hazir high.
   task automatic one_result(input string tag, input logic [8:0] w,
                             input logic [3:0] r, input logic last);
      step();
      chk({tag, "_buyruk"}, 32'(buyruk), 32'(w));
      chk({tag, "_bitti_mid"}, 32'(bitti), 32'd0);
      step();
      chk({tag, "_gecerli"}, 32'(bus.cikis_gecerli), 32'd1);
      chk({tag, "_veri"}, 32'(bus.cikis_veri), 32'(r));
      $display("result %s: buyruk=%03h veri=%0h", tag, buyruk, bus.cikis_veri);
      step();
      chk({tag, "_gecerli_clr"}, 32'(bus.cikis_gecerli), 32'd0);
      chk({tag, "_bitti"}, 32'(bitti), 32'(last));
      chk({tag, "_mesgul"}, 32'(mesgul), 32'(!last));
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_buyruk"}, 32'(buyruk), 32'd0);
      chk({tag, "_veri"}, 32'(bus.cikis_veri), 32'd0);
      chk({tag, "_gecerli"}, 32'(bus.cikis_gecerli), 32'd0);
      chk({tag, "_bitti"}, 32'(bitti), 32'd0);
      chk({tag, "_mesgul"}, 32'(mesgul), 32'd0);
      chk({tag, "_yaz_hazir"}, 32'(bus.yaz_hazir), 32'd1);
   endtask

   initial begin
      rst             = 1'b1;
      basla           = 1'b0;
      bus.yaz_gecerli = 1'b0;
      bus.yaz_veri    = '0;
      bus.cikis_hazir = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk_reset_values("reset");

      // Single add 3+2 = 5.
      wr(9'b000_011_010);
      start();
      chk("add_mesgul", 32'(mesgul), 32'd1);
      chk("add_yaz_hazir_busy", 32'(bus.yaz_hazir), 32'd0);
      one_result("add", 9'b000_011_010, 4'b0101, 1'b1);
      step();
      chk("add_bitti_once", 32'(bitti), 32'd0);

      // In-order batch including subtraction underflow.
      wr(9'b000_011_010);
      wr(9'b001_010_011);
      wr(9'b010_110_011);
      start();
      one_result("batch0", 9'b000_011_010, 4'd5, 1'b0);
      one_result("batch1", 9'b001_010_011, 4'b1111, 1'b0);
      one_result("batch2", 9'b010_110_011, 4'd2, 1'b1);
      step();

      // Backpressure in CIKIS for 5 cycles.
      wr(9'b000_001_001);
      wr(9'b010_111_101);
      bus.cikis_hazir = 1'b0;
      start();
      step();
      chk("bp_buyruk0", 32'(buyruk), 32'(9'b000_001_001));
      step();
      chk("bp_gecerli", 32'(bus.cikis_gecerli), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_veri", 32'(bus.cikis_veri), 32'd2);
         chk("bp_hold_gecerli", 32'(bus.cikis_gecerli), 32'd1);
         chk("bp_hold_buyruk", 32'(buyruk), 32'(9'b000_001_001));
      end
      bus.cikis_hazir = 1'b1;
      step();
      chk("bp_release_gecerli", 32'(bus.cikis_gecerli), 32'd0);
      chk("bp_release_bitti", 32'(bitti), 32'd0);
      one_result("bp1", 9'b010_111_101, 4'd5, 1'b1);
      step();

      // Fill to 8 (pointers wrap), 9th write dropped.
      for (int i = 0; i < 8; i++) begin
         chk("full_hazir_before", 32'(bus.yaz_hazir), 32'd1);
         wr({3'b000, 3'(i), 3'b001});
      end
      chk("full_hazir_after8", 32'(bus.yaz_hazir), 32'd0);
      wr(9'b010_111_111);
      chk("full_hazir_after9", 32'(bus.yaz_hazir), 32'd0);
      bus.yaz_gecerli = 1'b1;
      bus.yaz_veri    = 9'b001_111_000;
      start();
      for (int k = 0; k < 8; k++) begin
         if (k == 7) bus.yaz_gecerli = 1'b0;
         one_result("full", {3'b000, 3'(k), 3'b001}, 4'(k + 1), (k == 7));
      end
      step();
      chk("full_hazir_end", 32'(bus.yaz_hazir), 32'd1);
      start();
      chk("full_no_extra_mesgul", 32'(mesgul), 32'd0);

      // Start from empty buffer is ignored.
      step();
      start();
      chk("empty_mesgul", 32'(mesgul), 32'd0);
      step();
      chk("empty_bitti", 32'(bitti), 32'd0);

      // Write and basla in the same cycle starts a one-word run: 5-2 = 3.
      bus.yaz_gecerli = 1'b1;
      bus.yaz_veri    = 9'b001_101_010;
      start();
      bus.yaz_gecerli = 1'b0;
      chk("simul_mesgul", 32'(mesgul), 32'd1);
      one_result("simul", 9'b001_101_010, 4'd3, 1'b1);
      step();

      // Reset while holding a result in CIKIS with 3 words pending.
      wr(9'b000_111_111);
      wr(9'b000_001_010);
      wr(9'b000_010_010);
      bus.cikis_hazir = 1'b0;
      start();
      step();
      step();
      chk("rst_pre_gecerli", 32'(bus.cikis_gecerli), 32'd1);
      chk("rst_pre_veri", 32'(bus.cikis_veri), 32'd14);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.cikis_hazir = 1'b1;
      chk_reset_values("midrst");
      start();
      chk("midrst_start_mesgul", 32'(mesgul), 32'd0);
      step();
      chk("midrst_bitti", 32'(bitti), 32'd0);
      chk("midrst_gecerli", 32'(bus.cikis_gecerli), 32'd0);
      chk("midrst_buyruk", 32'(buyruk), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
